// File: rtl/ddr_axil_map_bridge.sv
// AXI4-lite slave to single-outstanding register-bus bridge for the DDR PHY host port.
// Decodes the DDR memory map, forwards region-relative offsets and returns DECERR/SLVERR.
module ddr_axil_map_bridge #(
  parameter int AWIDTH         = 32,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [AWIDTH-1:0]   i_awaddr,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DWIDTH-1:0]   i_wdata,
  input  logic [DWIDTH/8-1:0] i_wstrb,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic [1:0]          o_bresp,
  input  logic                i_arvalid,
  output logic                o_arready,
  input  logic [AWIDTH-1:0]   i_araddr,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic [DWIDTH-1:0]   o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_req,
  output logic                o_wr,
  output logic [4:0]          o_sel,
  output logic [23:0]         o_addr,
  output logic [DWIDTH-1:0]   o_wdata,
  output logic [DWIDTH/8-1:0] o_wstrb,
  input  logic                i_ack,
  input  logic [DWIDTH-1:0]   i_rdata,
  input  logic                i_err
);

  localparam int SW = DWIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic {PTR_WR, PTR_RD} ptr_e;

  typedef struct packed {
    logic        hit;
    logic [4:0]  sel;
    logic [23:0] off;
  } dec_t;

  // Regions are contiguous between holes, so an ordered upper-bound chain suffices.
  function automatic dec_t decode(input logic [AWIDTH-1:0] a);
    logic [63:0] x;
    logic [63:0] base;
    dec_t        d;
    x     = 64'(a);
    base  = '0;
    d     = '0;
    d.hit = 1'b1;
    if      (x < 64'h0000_4000) begin d.sel = 5'd0;  base = 64'h0000_0000; end
    else if (x < 64'h0000_8000) begin d.sel = 5'd1;  base = 64'h0000_4000; end
    else if (x < 64'h0001_0000) begin d.sel = 5'd2;  base = 64'h0000_8000; end
    else if (x < 64'h0002_0000) begin d.sel = 5'd3;  base = 64'h0001_0000; end
    else if (x < 64'h0005_0000) d.hit = 1'b0;
    else if (x < 64'h0006_0000) begin d.sel = 5'd4;  base = 64'h0005_0000; end
    else if (x < 64'h0009_0000) d.hit = 1'b0;
    else if (x < 64'h0009_8000) begin d.sel = 5'd5;  base = 64'h0009_0000; end
    else if (x < 64'h000A_0000) begin d.sel = 5'd6;  base = 64'h0009_8000; end
    else if (x < 64'h000B_0000) begin d.sel = 5'd7;  base = 64'h000A_0000; end
    else if (x < 64'h000C_0000) begin d.sel = 5'd8;  base = 64'h000B_0000; end
    else if (x < 64'h000D_0000) begin d.sel = 5'd9;  base = 64'h000C_0000; end
    else if (x < 64'h000E_0000) begin d.sel = 5'd10; base = 64'h000D_0000; end
    else if (x < 64'h000F_0000) begin d.sel = 5'd11; base = 64'h000E_0000; end
    else if (x < 64'h0010_0000) begin d.sel = 5'd12; base = 64'h000F_0000; end
    else if (x < 64'h0011_0000) begin d.sel = 5'd13; base = 64'h0010_0000; end
    else if (x < 64'h0012_0000) begin d.sel = 5'd14; base = 64'h0011_0000; end
    else if (x < 64'h0013_0000) begin d.sel = 5'd15; base = 64'h0012_0000; end
    else if (x < 64'h0014_0000) begin d.sel = 5'd16; base = 64'h0013_0000; end
    else if (x < 64'h0015_0000) begin d.sel = 5'd17; base = 64'h0014_0000; end
    else if (x < 64'h0100_0000) d.hit = 1'b0;
    else if (x < 64'h0200_0000) begin d.sel = 5'd18; base = 64'h0100_0000; end
    else                        d.hit = 1'b0;
    d.off = 24'(x - base);
    if (!d.hit) begin
      d.sel = '0;
      d.off = '0;
    end
    return d;
  endfunction

  state_e            state_q, state_d;
  ptr_e              ptr_q, ptr_d;
  logic              is_wr_q, is_wr_d;
  logic [4:0]        sel_q, sel_d;
  logic [23:0]       off_q, off_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        resp_q, resp_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              grant_wr, grant_rd;
  dec_t              dec;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    ptr_d    = ptr_q;
    is_wr_d  = is_wr_q;
    sel_d    = sel_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    dec      = '0;

    unique case (state_q)
      S_IDLE: begin
        grant_wr = !i_rst && i_awvalid && i_wvalid && (!i_arvalid || ptr_q == PTR_WR);
        grant_rd = !i_rst && i_arvalid && !grant_wr;
        if (grant_wr || grant_rd) begin
          dec     = decode(grant_wr ? i_awaddr : i_araddr);
          is_wr_d = grant_wr;
          ptr_d   = grant_wr ? PTR_RD : PTR_WR;
          sel_d   = dec.sel;
          off_d   = dec.off;
          rdata_d = '0;
          cnt_d   = '0;
          if (grant_wr) begin
            wdata_d = i_wdata;
            wstrb_d = i_wstrb;
          end
          // A miss skips the target entirely and answers on the next cycle.
          if (dec.hit) begin
            state_d = S_REQ;
            resp_d  = RESP_OKAY;
          end else begin
            state_d = S_RESP;
            resp_d  = RESP_DECERR;
          end
        end
      end
      S_REQ: begin
        if (i_ack) begin
          resp_d  = i_err ? RESP_SLVERR : RESP_OKAY;
          if (!is_wr_q) rdata_d = i_rdata;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (is_wr_q ? i_bready : i_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_WR;
      is_wr_q <= 1'b0;
      sel_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      is_wr_q <= is_wr_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_awready = grant_wr;
  assign o_wready  = grant_wr;
  assign o_arready = grant_rd;
  assign o_req     = (state_q == S_REQ);
  assign o_bvalid  = (state_q == S_RESP) &&  is_wr_q;
  assign o_rvalid  = (state_q == S_RESP) && !is_wr_q;
  assign o_bresp   = resp_q;
  assign o_rresp   = resp_q;
  assign o_rdata   = rdata_q;
  assign o_wr      = is_wr_q;
  assign o_sel     = sel_q;
  assign o_addr    = off_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;

endmodule
